bram_reader: RTL and testbench
==============================

BRAM_READER -- requirements
Module: bram_reader

Interface
REQ-001 Parameter WordLengthBits, default 8, bits per BRAM word.
REQ-002 Parameter NumWords, default 128, BRAM depth in words.
REQ-003 Parameter AddressWidthBits, default 7, BRAM address width; SHALL satisfy 2**AddressWidthBits == NumWords.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a burst read.
REQ-007 start_address  input  AddressWidthBits  first BRAM address of the burst.
REQ-008 word_count  input  AddressWidthBits+1  words to read, 0..NumWords.
REQ-009 busy  output  1  high from accepted start until done.
REQ-010 done  output  1  one-cycle pulse at burst completion.
REQ-011 bram_address  output  AddressWidthBits  address driven to the BRAM port.
REQ-012 bram_data  input  WordLengthBits  BRAM data_out, valid one clk after bram_address is presented.
REQ-013 data  output  WordLengthBits  stream word.
REQ-014 data_valid  output  1  stream valid.
REQ-015 data_ready  input  1  stream ready from consumer.

Function
REQ-016 start SHALL be sampled only in IDLE; start while busy SHALL be ignored; start_address and word_count SHALL be captured on the accepting edge.
REQ-017 States: IDLE, READ (issuing addresses), DRAIN (all addresses issued, buffer emptying); IDLE->READ on start with word_count>0; READ->DRAIN when last address issued; DRAIN->IDLE when last word transferred.
REQ-018 start with word_count==0 SHALL produce no data_valid; done SHALL pulse on the cycle after the accepting edge; busy SHALL stay low.
REQ-019 Addresses SHALL be issued sequentially from start_address, incrementing by 1 and wrapping from NumWords-1 to 0.
REQ-020 A read SHALL be issued only when buffered words plus in-flight reads is less than 2; the 2-entry output buffer SHALL never overflow.
REQ-021 A transfer occurs on an edge with data_valid && data_ready; data SHALL remain stable while data_valid && !data_ready.
REQ-022 Words SHALL emerge in address order with none dropped or duplicated under any data_ready pattern.
REQ-023 With data_ready held high, first data_valid SHALL assert 2 cycles after the accepting edge, followed by one word per cycle with no bubbles.
REQ-024 done SHALL pulse for exactly one cycle on the cycle after the final transfer; busy SHALL fall in that same cycle.
REQ-025 A new start SHALL be accepted no earlier than the cycle in which done is high.
REQ-026 The block SHALL never write the BRAM; the integrating level ties the BRAM write_enable low.

Reset
REQ-027 On rst, state SHALL go to IDLE; busy, done, data_valid, data and bram_address SHALL be 0; buffer and in-flight read SHALL be discarded.
REQ-028 rst mid-burst SHALL abort with no done pulse; the first cycle after rst releases SHALL accept a new start.

Structure
REQ-029 The state enum typedef SHALL live in shared package bram_pkg, alongside the bram word/address parameters used by bram and bram_reader.
REQ-030 The 2-entry output buffer SHALL be a sub-module named skid_buffer, parameterized by WordLengthBits.

Verification
REQ-031 Preload addresses 0..3 with 8'h01..8'h04; start at 0, count 4, data_ready=1 -> 8'h01..8'h04 on 4 consecutive cycles, first 2 cycles after start; done pulses once.
REQ-032 Preload 126, 127, 0 with 8'hAA, 8'hBB, 8'hCC; start at 126, count 3 -> AA, BB, CC (wrap).
REQ-033 Count 8, data_ready toggling 1,0,0,1,... -> all 8 words in order; data stable while stalled; no loss.
REQ-034 Count 0 -> no data_valid; done pulses one cycle after start; second start during a count-5 burst is ignored.
REQ-035 rst asserted after 2 of 6 words transferred -> outputs 0 next cycle, no done; new count-1 burst completes correctly.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared BRAM word/address parameters and the burst reader state type.
package bram_pkg;

    localparam int BRAM_WORD_BITS = 8;
    localparam int BRAM_NUM_WORDS = 128;
    localparam int BRAM_ADDR_BITS = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } reader_state_e;

endpackage : bram_pkg

// File: rtl/bram_reader_if.sv
// Command, BRAM read port and output stream of the burst reader.
// The slave modport is the reader's view; master is the surrounding logic.
interface bram_reader_if
    import bram_pkg::*;
#(
    parameter int WordLengthBits   = BRAM_WORD_BITS,
    parameter int AddressWidthBits = BRAM_ADDR_BITS
) ();

    logic                        start;
    logic [AddressWidthBits-1:0] start_address;
    logic [AddressWidthBits:0]   word_count;
    logic                        busy;
    logic                        done;
    logic [AddressWidthBits-1:0] bram_address;
    logic [WordLengthBits-1:0]   bram_data;
    logic [WordLengthBits-1:0]   data;
    logic                        data_valid;
    logic                        data_ready;

    modport slave (
        input  start, start_address, word_count, bram_data, data_ready,
        output busy, done, bram_address, data, data_valid
    );

    modport master (
        output start, start_address, word_count, bram_data, data_ready,
        input  busy, done, bram_address, data, data_valid
    );

endinterface : bram_reader_if

// File: rtl/bram_reader_skid_buffer.sv
// Two-entry FIFO that holds words returned by the BRAM until the consumer
// takes them. The head word stays put while the consumer stalls.
module skid_buffer #(
    parameter int WordLengthBits = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  logic [WordLengthBits-1:0] push_data_i,
    input  logic                      pop_i,
    output logic                      valid_o,
    output logic [WordLengthBits-1:0] data_o,
    output logic [1:0]                count_o
);

    logic                      rd_ptr_q;
    logic                      wr_ptr_q;
    logic [1:0]                count_q;
    logic [WordLengthBits-1:0] entry [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [WordLengthBits-1:0] entry_q;

            // Capture the returning BRAM word into the slot the write pointer selects.
            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_q <= '0;
                end else if (push_i && (wr_ptr_q == 1'(gi))) begin
                    entry_q <= push_data_i;
                end
            end

            assign entry[gi] = entry_q;
        end
    endgenerate

    // Pointer and occupancy bookkeeping; push and pop may coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push_i) - 2'(pop_i);
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign data_o  = entry[rd_ptr_q];
    assign count_o = count_q;

endmodule : skid_buffer

// File: rtl/bram_reader.sv
// Burst reader: streams word_count consecutive BRAM words, starting at
// start_address and wrapping at the top of memory, onto a valid/ready stream.
// The first address goes to the BRAM on the accepting cycle so the first word
// is presented two cycles after the accepting edge.
module bram_reader
    import bram_pkg::*;
#(
    parameter int WordLengthBits   = BRAM_WORD_BITS,
    parameter int NumWords         = BRAM_NUM_WORDS,
    parameter int AddressWidthBits = BRAM_ADDR_BITS
) (
    input  logic          clk,
    input  logic          rst,
    bram_reader_if.slave  rd_bus
);

    reader_state_e               state_q,    state_d;
    logic [AddressWidthBits-1:0] addr_q,     addr_d;
    logic [AddressWidthBits:0]   to_issue_q, to_issue_d;
    logic [AddressWidthBits:0]   to_xfer_q,  to_xfer_d;
    logic                        inflight_q, inflight_d;
    logic                        done_q,     done_d;

    logic [AddressWidthBits-1:0] bram_addr_c;
    logic                        buf_valid;
    logic [WordLengthBits-1:0]   buf_data;
    logic [1:0]                  buf_count;
    logic                        pop;
    logic [2:0]                  occ_after;
    logic                        room;

    function automatic logic [AddressWidthBits-1:0] wrap_inc(
        input logic [AddressWidthBits-1:0] a
    );
        return (a == AddressWidthBits'(NumWords - 1)) ? '0 : a + 1'b1;
    endfunction

    skid_buffer #(
        .WordLengthBits (WordLengthBits)
    ) u_skid_buffer (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i (rd_bus.bram_data),
        .pop_i       (pop),
        .valid_o     (buf_valid),
        .data_o      (buf_data),
        .count_o     (buf_count)
    );

    assign pop = buf_valid && rd_bus.data_ready;

    // Words held after this edge's transfer plus the read already in flight;
    // counting the departing word keeps the stream bubble-free at full rate.
    assign occ_after = {1'b0, buf_count} + {2'b0, inflight_q} - {2'b0, pop};
    assign room      = (occ_after < 3'd2);

    // Next-state, read issue and completion decisions.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        to_issue_d  = to_issue_q;
        to_xfer_d   = to_xfer_q;
        inflight_d  = 1'b0;
        done_d      = 1'b0;
        bram_addr_c = addr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (rd_bus.start) begin
                    if (rd_bus.word_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        bram_addr_c = rd_bus.start_address;
                        inflight_d  = 1'b1;
                        addr_d      = wrap_inc(rd_bus.start_address);
                        to_issue_d  = rd_bus.word_count - 1'b1;
                        to_xfer_d   = rd_bus.word_count;
                        state_d     = (rd_bus.word_count == 1) ? ST_DRAIN : ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (pop) begin
                    to_xfer_d = to_xfer_q - 1'b1;
                end
                if (room) begin
                    inflight_d = 1'b1;
                    addr_d     = wrap_inc(addr_q);
                    to_issue_d = to_issue_q - 1'b1;
                    if (to_issue_q == 1) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop) begin
                    to_xfer_d = to_xfer_q - 1'b1;
                    if (to_xfer_q == 1) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and burst bookkeeping registers; reset drops any burst in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            to_issue_q <= '0;
            to_xfer_q  <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            to_issue_q <= to_issue_d;
            to_xfer_q  <= to_xfer_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

    // Address stays at zero while reset is held, even if start is asserted.
    assign rd_bus.bram_address = rst ? '0 : bram_addr_c;
    assign rd_bus.busy         = (state_q != ST_IDLE);
    assign rd_bus.done         = done_q;
    assign rd_bus.data         = buf_data;
    assign rd_bus.data_valid   = buf_valid;

endmodule : bram_reader

// File: tb/tb_bram_reader.sv
// Directed bench for bram_reader with a queue-based stream model.
module tb_bram_reader;

    logic clk;
    logic rst;

    bram_reader_if #(.WordLengthBits(8), .AddressWidthBits(7)) ifc ();

    bram_reader dut (
        .clk    (clk),
        .rst    (rst),
        .rd_bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: registered read, never written by the DUT.
    logic [7:0] mem [128];
    always @(posedge clk) begin
        ifc.bram_data <= mem[ifc.bram_address];
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc = 0;

    logic [7:0] exp_q [$];
    logic [7:0] xfer_d [$];
    int         xfer_c [$];
    int         done_c [$];
    bit         m_active = 1'b0;
    bit         exp_done = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    int         m_left = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model and compare: sampled late in each cycle, describes the coming edge.
    always begin
        bit         nd;
        bit         was_active;
        @(negedge clk);
        #3;
        cyc++;
        if (rst) begin
            exp_q.delete();
            m_active   = 1'b0;
            m_left     = 0;
            exp_done   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("done", ifc.done, exp_done);
            check("busy", ifc.busy, m_active);
            if (prev_stall) begin
                check("stall_valid", ifc.data_valid, 1);
                check("stall_data", ifc.data, prev_data);
            end
            if (ifc.data_valid) begin
                if (exp_q.size() == 0) check("valid_when_empty", ifc.data_valid, 0);
                else check("data", ifc.data, exp_q[0]);
            end
            nd = 1'b0;
            was_active = m_active;
            if (ifc.data_valid && ifc.data_ready) begin
                xfer_d.push_back(ifc.data);
                xfer_c.push_back(cyc);
                $display("xfer cycle=%0d data=%02h", cyc, ifc.data);
                if (exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    m_left--;
                    if (m_left == 0) begin
                        m_active = 1'b0;
                        nd = 1'b1;
                    end
                end
            end
            if (ifc.done) done_c.push_back(cyc);
            if (!was_active && ifc.start) begin
                if (ifc.word_count == 0) begin
                    nd = 1'b1;
                end else begin
                    m_active = 1'b1;
                    m_left = int'(ifc.word_count);
                    for (int i = 0; i < int'(ifc.word_count); i++)
                        exp_q.push_back(mem[(int'(ifc.start_address) + i) % 128]);
                end
            end
            exp_done   = nd;
            prev_stall = ifc.data_valid && !ifc.data_ready;
            prev_data  = ifc.data;
        end
    end

    task automatic clear_logs();
        xfer_d.delete();
        xfer_c.delete();
        done_c.delete();
    endtask

    task automatic do_start(input int sa, input int wc);
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.start_address = 7'(sa);
        ifc.word_count = 8'(wc);
        #4;
        start_cyc = cyc;
        $display("start cycle=%0d addr=%0d count=%0d", cyc, sa, wc);
        @(negedge clk);
        ifc.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int k = 0; k < budget && done_c.size() == 0; k++) @(negedge clk);
        repeat (4) @(negedge clk);
        check(name, done_c.size(), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'(i * 7 + 3);
        rst = 1'b1;
        ifc.start = 1'b0;
        ifc.start_address = '0;
        ifc.word_count = '0;
        ifc.data_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", ifc.busy, 0);
        check("rst_done", ifc.done, 0);
        check("rst_valid", ifc.data_valid, 0);
        check("rst_data", ifc.data, 0);
        check("rst_addr", ifc.bram_address, 0);
        rst = 1'b0;

        // Basic burst at full rate.
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
        clear_logs();
        do_start(0, 4);
        wait_done("t1_done_once", 50);
        check("t1_count", xfer_d.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("t1_word", xfer_d[i], 32'(i + 1));
            check("t1_cycle", xfer_c[i], start_cyc + 2 + i);
        end
        check("t1_done_cycle", done_c[0], start_cyc + 6);

        // Address wrap.
        mem[126] = 8'hAA; mem[127] = 8'hBB; mem[0] = 8'hCC;
        clear_logs();
        do_start(126, 3);
        wait_done("t2_done_once", 50);
        check("t2_count", xfer_d.size(), 3);
        check("t2_w0", xfer_d[0], 8'hAA);
        check("t2_w1", xfer_d[1], 8'hBB);
        check("t2_w2", xfer_d[2], 8'hCC);

        // Back-pressure with ready pattern 1,0,0 repeating.
        for (int i = 0; i < 8; i++) mem[16 + i] = 8'(8'h30 + i);
        clear_logs();
        do_start(16, 8);
        for (int k = 0; k < 200 && done_c.size() == 0; k++) begin
            ifc.data_ready = (k % 3 == 0);
            @(negedge clk);
        end
        ifc.data_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("t3_done_once", done_c.size(), 1);
        check("t3_count", xfer_d.size(), 8);
        for (int i = 0; i < 8; i++) check("t3_word", xfer_d[i], 32'(8'h30 + i));

        // Zero-length burst, then a start during a burst is ignored.
        clear_logs();
        do_start(5, 0);
        wait_done("t4_zero_done_once", 10);
        check("t4_zero_done_cycle", done_c[0], start_cyc + 1);
        check("t4_zero_count", xfer_d.size(), 0);
        for (int i = 0; i < 5; i++) mem[40 + i] = 8'(8'hE0 + i);
        clear_logs();
        do_start(40, 5);
        do_start(100, 3);
        wait_done("t4_done_once", 50);
        check("t4_count", xfer_d.size(), 5);
        for (int i = 0; i < 5; i++) check("t4_word", xfer_d[i], 32'(8'hE0 + i));

        // Reset after two of six words, then a one-word burst.
        clear_logs();
        do_start(60, 6);
        for (int k = 0; k < 50 && xfer_d.size() < 2; k++) @(negedge clk);
        check("t5_two_before_rst", xfer_d.size(), 2);
        rst = 1'b1;
        ifc.data_ready = 1'b0;
        @(posedge clk);
        #1;
        check("t5_rst_valid", ifc.data_valid, 0);
        check("t5_rst_data", ifc.data, 0);
        check("t5_rst_busy", ifc.busy, 0);
        check("t5_rst_done", ifc.done, 0);
        check("t5_rst_addr", ifc.bram_address, 0);
        mem[7] = 8'h77;
        @(negedge clk);
        rst = 1'b0;
        ifc.data_ready = 1'b1;
        check("t5_no_done", done_c.size(), 0);
        check("t5_no_more_words", xfer_d.size(), 2);
        clear_logs();
        ifc.start = 1'b1;
        ifc.start_address = 7'd7;
        ifc.word_count = 8'd1;
        #4;
        start_cyc = cyc;
        @(negedge clk);
        ifc.start = 1'b0;
        wait_done("t5_done_once", 20);
        check("t5_count", xfer_d.size(), 1);
        check("t5_word", xfer_d[0], 8'h77);
        check("t5_cycle", xfer_c[0], start_cyc + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bram_reader
